// File: rtl/clk_div_multi_pkg.sv
// clk_div_multi_pkg: shared constants and helpers for the multi-channel clock divider
package clk_div_multi_pkg;
  localparam int HALTED = 0;
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/clk_div_multi_chan.sv
// clk_div_multi_chan: one divider channel with shadowed half-period and registered strobes
module clk_div_multi_chan
  import clk_div_multi_pkg::*;
#(
  parameter int WIDTH        = 24,
  parameter int DEFAULT_HALF = 25_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_data,
  output logic             div,
  output logic             tick,
  output logic             rise
);
  logic [WIDTH-1:0] cnt, active, shadow;
  logic idle, terminal;
  assign idle     = !en || active == WIDTH'(HALTED);
  assign terminal = cnt == active - WIDTH'(1);
  // count within a level; shadow moves to active only at cnt==0 boundaries so no period is cut short
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      div    <= 1'b0;
      tick   <= 1'b0;
      rise   <= 1'b0;
      active <= WIDTH'(DEFAULT_HALF);
      shadow <= WIDTH'(DEFAULT_HALF);
    end else begin
      if (wr) shadow <= wr_data;
      if (sync || idle) begin
        cnt    <= '0;
        div    <= 1'b0;
        tick   <= 1'b0;
        rise   <= 1'b0;
        active <= shadow;
      end else if (terminal) begin
        cnt    <= '0;
        div    <= ~div;
        tick   <= 1'b1;
        rise   <= ~div;
        active <= shadow;
      end else begin
        cnt  <= cnt + WIDTH'(1);
        tick <= 1'b0;
        rise <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: N-channel programmable clock/tick divider with common phase sync
module clk_div_multi
  import clk_div_multi_pkg::*;
#(
  parameter int  CHANNELS     = 4,
  parameter int  WIDTH        = 24,
  parameter int  DEFAULT_HALF = 25_000,
  localparam int CH_W         = ch_width(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] en_i,
  input  logic                sync_i,
  input  logic                wr_en_i,
  input  logic [CH_W-1:0]     wr_ch_i,
  input  logic [WIDTH-1:0]    wr_data_i,
  output logic [CHANNELS-1:0] clk_o,
  output logic [CHANNELS-1:0] tick_o,
  output logic [CHANNELS-1:0] rise_o
);
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic wr;
    assign wr = wr_en_i && int'(wr_ch_i) == i;
    clk_div_multi_chan #(.WIDTH(WIDTH), .DEFAULT_HALF(DEFAULT_HALF)) u_chan (
      .clk(clk), .rst_n(rst_n), .en(en_i[i]), .sync(sync_i), .wr(wr), .wr_data(wr_data_i),
      .div(clk_o[i]), .tick(tick_o[i]), .rise(rise_o[i])
    );
  end
endmodule
